// File: rtl/point_and_ary_pkg.sv
// Shared types for the serial-to-parallel point-AND operand loader.
// Build option POINT_AND_ARY_FLAG_EN adds the registered d0 flag.
package point_and_ary_pkg;

   localparam int N_DEF = 8;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } ld_state_t;

   typedef logic [N_DEF-1:0] word_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/point_and_ary_loader_if.sv
// Bit-stream input and word output handshakes of the operand loader.
// Build option POINT_AND_ARY_FLAG_EN adds out_d0 to the bundle.
interface point_and_ary_loader_if #(
   parameter int N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic         in_a;
   logic         in_b;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_a;
   logic [N-1:0] out_b;
   logic         out_short;
`ifdef POINT_AND_ARY_FLAG_EN
   logic         out_d0;

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_a, out_b, out_short, out_d0
   );

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_short, out_d0
   );
`else
   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_a, out_b, out_short
   );

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_short
   );
`endif
endinterface

// File: rtl/point_and_ary_outreg.sv
// Output holding register: captures a finished word on load, clears on transfer.
// Build option POINT_AND_ARY_FLAG_EN adds the d0 bit to the held word.
module point_and_ary_outreg #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_ready,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_short,
`ifdef POINT_AND_ARY_FLAG_EN
   input  logic         i_d0,
   output logic         o_d0,
`endif
   output logic         o_valid,
   output logic [N-1:0] o_a,
   output logic [N-1:0] o_b,
   output logic         o_short
);

   logic         r_valid;
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;
   logic         r_short;

   // Load wins over transfer: a HOLD-cycle beat may close a new word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_short <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_a     <= i_a;
         r_b     <= i_b;
         r_short <= i_short;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

`ifdef POINT_AND_ARY_FLAG_EN
   logic r_d0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_d0 <= 1'b0;
      end else if (i_load) begin
         r_d0 <= i_d0;
      end
   end

   assign o_d0 = r_d0;
`endif

   assign o_valid = r_valid;
   assign o_a     = r_a;
   assign o_b     = r_b;
   assign o_short = r_short;

endmodule

// File: rtl/point_and_ary_loader.sv
// Serial (a,b) bit-pair loader assembling N-bit operand words for point-AND.
// Build option POINT_AND_ARY_FLAG_EN adds out_d0 = &(out_a ^ out_b).
module point_and_ary_loader
   import point_and_ary_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter bit LSB_FIRST = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   point_and_ary_loader_if.slave bus
);

   localparam int CW = clog2(N);

   ld_state_t    r_state;
   ld_state_t    w_next;
   logic [CW-1:0] r_cnt;
   logic [N-1:0] r_sh_a;
   logic [N-1:0] r_sh_b;

   logic          w_in_ready;
   logic          w_accept;
   logic          w_xfer;
   logic          w_first;
   logic          w_full;
   logic          w_close;
   logic          w_short;
   logic          w_load;
   logic [CW-1:0] w_pos;
   logic [N-1:0]  w_onehot;
   logic [N-1:0]  w_word_a;
   logic [N-1:0]  w_word_b;

   assign w_accept = bus.in_valid & w_in_ready;
   assign w_xfer   = bus.out_valid & bus.out_ready;
   assign w_first  = (r_cnt == '0);
   assign w_full   = (r_cnt == CW'(N - 1));
   assign w_close  = w_accept & (w_full | bus.in_last);
   assign w_short  = bus.in_last & ~w_full;

   assign w_pos    = LSB_FIRST ? r_cnt : (CW'(N - 1) - r_cnt);
   assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_pos;

   // Word start discards stale shadow bits so short words zero-fill
   assign w_word_a = (w_first ? '0 : r_sh_a)
                   | (bus.in_a ? w_onehot : '0);
   assign w_word_b = (w_first ? '0 : r_sh_b)
                   | (bus.in_b ? w_onehot : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         FILL: if (w_close) w_next = HOLD;
         HOLD: if (w_xfer) w_next = w_close ? HOLD : FILL;
      endcase
   end

   always_comb begin
      w_in_ready = 1'b1;
      w_load     = w_close;
      unique case (r_state)
         FILL: w_in_ready = 1'b1;
         HOLD: w_in_ready = bus.out_ready;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_sh_a <= '0;
         r_sh_b <= '0;
      end else if (w_accept) begin
         r_cnt  <= w_close ? '0 : r_cnt + 1'b1;
         r_sh_a <= w_word_a;
         r_sh_b <= w_word_b;
      end
   end

`ifdef POINT_AND_ARY_FLAG_EN
   logic r_f;
   logic w_f;
   logic w_d0;

   assign w_f  = (w_first | r_f) & (bus.in_a ^ bus.in_b);
   assign w_d0 = w_f & ~w_short;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_f <= 1'b1;
      end else if (w_accept) begin
         r_f <= w_f;
      end
   end
`endif

   point_and_ary_outreg #(
      .N(N)
   ) u_outreg (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_ready(bus.out_ready),
      .i_a    (w_word_a),
      .i_b    (w_word_b),
      .i_short(w_short),
`ifdef POINT_AND_ARY_FLAG_EN
      .i_d0   (w_d0),
      .o_d0   (bus.out_d0),
`endif
      .o_valid(bus.out_valid),
      .o_a    (bus.out_a),
      .o_b    (bus.out_b),
      .o_short(bus.out_short)
   );

   assign bus.in_ready = w_in_ready;

endmodule
